// File: rtl/uart_tx_16x.sv
// UART transmitter paced by a 16x-baud strobe, with a one-byte holding register for gap-free frames.
// Latency: start bit goes out one clock after the holding register fills while idle; every bit is 16 enable_16 ticks.
// Backpressure: tx_ready low while the holding register is full; a write then is dropped and flagged on tx_overrun.
module uart_tx_16x #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       enable_16,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_overrun,
  output logic       uart_tx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Mask for the data bits actually sent; upper tx_data bits never reach the line.
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t     state;
  logic [3:0] tick;
  logic [2:0] bit_idx;
  logic       stop_idx;
  logic [7:0] shifter;
  logic       par_bit;
  logic       hold_full;
  logic [7:0] hold_dat;

  logic bit_end;
  logic wr_acc;
  logic load;

  assign bit_end  = enable_16 && (tick == 4'd15);
  assign wr_acc   = tx_wr && !hold_full;
  // The holding byte moves to the shifter either from idle or straight out of the final stop bit.
  assign load     = hold_full &&
                    ((state == S_IDLE) ||
                     ((state == S_STOP) && bit_end && (stop_idx == LAST_STOP)));
  assign tx_ready = ~hold_full;

  // Holding register: filled by an accepted write, emptied when the byte moves to the shifter.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hold_full  <= 1'b0;
      hold_dat   <= 8'h00;
      tx_overrun <= 1'b0;
    end else begin
      tx_overrun <= tx_wr && hold_full;
      if (wr_acc) begin
        hold_dat  <= tx_data & DATA_MASK;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Frame sequencer: bit timing, shifting, and the registered line/status outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      tick     <= 4'd0;
      bit_idx  <= 3'd0;
      stop_idx <= 1'b0;
      shifter  <= 8'h00;
      par_bit  <= 1'b0;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (enable_16 && (state != S_IDLE)) begin
        tick <= tick + 4'd1;
      end
      case (state)
        S_IDLE: begin
          if (hold_full) begin
            shifter <= hold_dat;
            par_bit <= (PARITY == 1) ? ~^hold_dat : ^hold_dat;
            tick    <= 4'd0;
            state   <= S_START;
            uart_tx <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= 3'd0;
            uart_tx <= shifter[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_BIT) begin
              if (PARITY != 0) begin
                state   <= S_PARITY;
                uart_tx <= par_bit;
              end else begin
                state    <= S_STOP;
                stop_idx <= 1'b0;
                uart_tx  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shifter <= shifter >> 1;
              uart_tx <= shifter[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state    <= S_STOP;
            stop_idx <= 1'b0;
            uart_tx  <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (stop_idx != LAST_STOP) begin
              stop_idx <= 1'b1;
            end else begin
              tx_done <= 1'b1;
              if (hold_full) begin
                // Next frame starts immediately: no idle gap between frames.
                shifter <= hold_dat;
                par_bit <= (PARITY == 1) ? ~^hold_dat : ^hold_dat;
                tick    <= 4'd0;
                state   <= S_START;
                uart_tx <= 1'b0;
              end else begin
                state   <= S_IDLE;
                uart_tx <= 1'b1;
                tx_busy <= 1'b0;
              end
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
